// File: rtl/interp_pkg.sv
// Shared definitions for the 4-tap fractional-sample interpolation filter:
// tap count, fraction count, tap signs and the pipeline stage bundles.
package interp_pkg;

    localparam int NUM_TAPS = 4;
    localparam int NUM_FRAC = 15;
    localparam int PROD_W   = 32;
    localparam int BUS_W    = NUM_FRAC * PROD_W;

    // Bit k-1 set means tap k is subtracted (taps 1 and 4 are negative).
    localparam logic [NUM_TAPS-1:0] TAP_SIGN = 4'b1001;

    typedef logic signed [PROD_W-1:0] prod_t;

    typedef struct packed {
        logic  v;
        prod_t p1;
        prod_t p2;
        prod_t p3;
        prod_t p4;
    } sel_stage_t;

    typedef struct packed {
        logic  v;
        prod_t a;
        prod_t b;
    } sum_stage_t;

    function automatic prod_t signed_tap(input prod_t x, input logic neg);
        prod_t r;
        if (neg) begin
            r = -x;
        end else begin
            r = x;
        end
        return r;
    endfunction

endpackage

// File: rtl/interp_sum_stage_if.sv
// Valid/ready stream and tap-bus bundle between the MCM blocks, the
// combining stage and its downstream consumer.
interface interp_sum_stage_if;
    import interp_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [3:0]              in_frac;
    logic signed [31:0]      in_sample;
    logic [BUS_W-1:0]        t1_bus;
    logic [BUS_W-1:0]        t2_bus;
    logic [BUS_W-1:0]        t3_bus;
    logic [BUS_W-1:0]        t4_bus;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [15:0]      out_sample;

    modport master (
        output in_valid, in_frac, in_sample, t1_bus, t2_bus, t3_bus, t4_bus, out_ready,
        input  in_ready, out_valid, out_sample
    );

    modport slave (
        input  in_valid, in_frac, in_sample, t1_bus, t2_bus, t3_bus, t4_bus, out_ready,
        output in_ready, out_valid, out_sample
    );

endinterface

// File: rtl/interp_tap_sel.sv
// Picks product Yk for fraction k from one tap's 15-product MCM bus;
// fraction 0 (integer position) yields zero.
module interp_tap_sel
    import interp_pkg::*;
(
    input  logic [BUS_W-1:0] bus,
    input  logic [3:0]       frac,
    output prod_t            prod
);

    logic [3:0] idx_s;

    // Slice Yk lives at [32k-1:32(k-1)].
    always_comb begin
        idx_s = frac - 4'd1;
        if (frac == 4'd0) begin
            prod = {PROD_W{1'b0}};
        end else begin
            prod = bus[{idx_s, 5'd0} +: PROD_W];
        end
    end

endmodule

// File: rtl/interp_sum_stage.sv
// 3-stage select / partial-sum / round-shift-clip combiner of the interpolation filter.
// Define INTERP_SUM_CLIP_EN for the final-pass clip to [0, 2^BIT_DEPTH-1]; otherwise r[15:0].
module interp_sum_stage
    import interp_pkg::*;
#(
    parameter int BIT_DEPTH = 10,
    parameter int SHIFT     = 6
) (
    input logic               clk,
    input logic               rst_n,
    interp_sum_stage_if.slave io
);

`ifdef INTERP_SUM_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    localparam prod_t ROUND   = prod_t'(32'sd1 <<< (SHIFT - 1));
    localparam prod_t PIX_MAX = prod_t'((32'sd1 <<< BIT_DEPTH) - 32'sd1);

    function automatic logic signed [15:0] finalize(input prod_t r);
        logic signed [15:0] o;
        if (CLIP_EN && (r < 32'sd0)) begin
            o = 16'sd0;
        end else if (CLIP_EN && (r > PIX_MAX)) begin
            o = PIX_MAX[15:0];
        end else begin
            o = r[15:0];
        end
        return o;
    endfunction

    prod_t y1_s, y2_s, y3_s, y4_s;

    interp_tap_sel u_sel1 (.bus(io.t1_bus), .frac(io.in_frac), .prod(y1_s));
    interp_tap_sel u_sel2 (.bus(io.t2_bus), .frac(io.in_frac), .prod(y2_s));
    interp_tap_sel u_sel3 (.bus(io.t3_bus), .frac(io.in_frac), .prod(y3_s));
    interp_tap_sel u_sel4 (.bus(io.t4_bus), .frac(io.in_frac), .prod(y4_s));

    sel_stage_t         s1_q, s1_d;
    sum_stage_t         s2_q, s2_d;
    logic               v3_q, v3_d;
    logic signed [15:0] out_sample_q, out_sample_d;
    logic               en1_s, en2_s, en3_s;
    prod_t              sum_s, r_s;

    // A stage may advance when it is empty or its successor advances.
    assign en3_s = !v3_q || io.out_ready;
    assign en2_s = !s2_q.v || en3_s;
    assign en1_s = !s1_q.v || en2_s;

    assign io.in_ready   = en1_s;
    assign io.out_valid  = v3_q;
    assign io.out_sample = out_sample_q;

    // Next-state for all three stages; data only moves with a valid set.
    always_comb begin
        s1_d         = s1_q;
        s2_d         = s2_q;
        v3_d         = v3_q;
        out_sample_d = out_sample_q;
        sum_s        = s2_q.a + s2_q.b + ROUND;
        r_s          = sum_s >>> SHIFT;

        if (en1_s && io.in_valid) begin
            s1_d.p1 = y1_s;
            s1_d.p3 = y3_s;
            s1_d.p4 = y4_s;
            if (io.in_frac == 4'd0) begin
                s1_d.p2 = io.in_sample <<< SHIFT;
            end else begin
                s1_d.p2 = y2_s;
            end
        end else begin
            s1_d = s1_q;
        end
        s1_d.v = en1_s ? io.in_valid : s1_q.v;

        if (en2_s && s1_q.v) begin
            s2_d.a = signed_tap(s1_q.p2, TAP_SIGN[1]) + signed_tap(s1_q.p1, TAP_SIGN[0]);
            s2_d.b = signed_tap(s1_q.p3, TAP_SIGN[2]) + signed_tap(s1_q.p4, TAP_SIGN[3]);
        end else begin
            s2_d = s2_q;
        end
        s2_d.v = en2_s ? s1_q.v : s2_q.v;

        if (en3_s && s2_q.v) begin
            out_sample_d = finalize(r_s);
        end else begin
            out_sample_d = out_sample_q;
        end
        v3_d = en3_s ? s2_q.v : v3_q;
    end

    // Pipeline registers; reset drops every in-flight set at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q         <= {$bits(sel_stage_t){1'b0}};
            s2_q         <= {$bits(sum_stage_t){1'b0}};
            v3_q         <= 1'b0;
            out_sample_q <= 16'sd0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            v3_q         <= v3_d;
            out_sample_q <= out_sample_d;
        end
    end

endmodule

// File: tb/tb_interp_sum_stage.sv
// Directed plus randomized bench for interp_sum_stage with a queue-based reference model.
module tb_interp_sum_stage;
    import interp_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    interp_sum_stage_if io();

    interp_sum_stage #(.BIT_DEPTH(10), .SHIFT(6)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (io)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];
    int exp_cur  = 0;
    int n_acc    = 0;
    int n_out    = 0;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    // Filter result straight from the sample definition: signed tap sum, round half up, floor divide.
    function automatic int model(input int frac, input int samp, input int y1, input int y2, input int y3, input int y4);
        int sum;
        int q;
        logic [31:0] qb;
        logic signed [15:0] t;
        if (frac == 0) sum = samp * 64;
        else           sum = y2 + y3 - y1 - y4;
        sum = sum + 32;
        if (sum >= 0) q = sum / 64;
        else          q = -((-sum + 63) / 64);
`ifdef INTERP_SUM_CLIP_EN
        if (q < 0)    return 0;
        if (q > 1023) return 1023;
        return q;
`else
        qb = q;
        t  = qb[15:0];
        return int'(t);
`endif
    endfunction

    task automatic drive(input int frac, input int samp, input int y1, input int y2, input int y3, input int y4);
        logic [479:0] b1, b2, b3, b4;
        for (int k = 0; k < 15; k++) begin
            b1[32*k +: 32] = $urandom;
            b2[32*k +: 32] = $urandom;
            b3[32*k +: 32] = $urandom;
            b4[32*k +: 32] = $urandom;
        end
        if (frac != 0) begin
            b1[32*(frac-1) +: 32] = y1;
            b2[32*(frac-1) +: 32] = y2;
            b3[32*(frac-1) +: 32] = y3;
            b4[32*(frac-1) +: 32] = y4;
        end
        io.t1_bus    = b1;
        io.t2_bus    = b2;
        io.t3_bus    = b3;
        io.t4_bus    = b4;
        io.in_frac   = 4'(frac);
        io.in_sample = samp;
        io.in_valid  = 1'b1;
        exp_cur      = model(frac, samp, y1, y2, y3, y4);
    endtask

    function automatic int rnd_y();
        return int'($urandom_range(0, 32'h0FFF_FFFF)) - 134217728;
    endfunction

    task automatic drive_rand();
        int f;
        int s;
        f = int'($urandom_range(0, 15));
        s = int'($urandom_range(0, 32'h00FF_FFFF)) - 8388608;
        drive(f, s, rnd_y(), rnd_y(), rnd_y(), rnd_y());
    endtask

    // One clock: score the output handshake, record an input accept, advance to the next falling edge.
    task automatic cycle();
        #1;
        if (io.out_valid && io.out_ready) begin
            check("sb_nonempty", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("out_sample", io.out_sample, exp_q.pop_front());
            n_out++;
        end
        if (io.in_valid && io.in_ready) begin
            exp_q.push_back(exp_cur);
            n_acc++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle();
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic single(input string tag, input int expv);
        cycle();
        io.in_valid = 1'b0;
        check({tag, "_lat1"}, io.out_valid, 0);
        cycle();
        check({tag, "_lat2"}, io.out_valid, 0);
        cycle();
        check({tag, "_lat3"}, io.out_valid, 1);
        check({tag, "_value"}, io.out_sample, expv);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        io.in_valid  = 1'b0;
        io.in_frac   = 4'd0;
        io.in_sample = 32'sd0;
        io.t1_bus    = '0;
        io.t2_bus    = '0;
        io.t3_bus    = '0;
        io.t4_bus    = '0;
        io.out_ready = 1'b1;
        rst_n        = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", io.out_valid, 0);
        check("rst_out_sample", io.out_sample, 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", io.in_ready, 1);
        @(negedge clk);

        drive(2, 0, 200, 6200, 400, 0);
        single("basic", 100);

        drive(0, 517, rnd_y(), rnd_y(), rnd_y(), rnd_y());
        single("int_pos", 517);

`ifdef INTERP_SUM_CLIP_EN
        drive(3, 0, 6400, 0, 0, 0);
        single("clip_low", 0);
        drive(5, 0, 0, 80000, 0, 0);
        single("clip_high", 1023);
`else
        drive(3, 0, 6400, 0, 0, 0);
        single("noclip_neg", -100);
        drive(5, 0, 0, 80000, 0, 0);
        single("noclip_big", 1250);
`endif

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) != 0) drive_rand();
            else io.in_valid = 1'b0;
            io.out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        n_acc = 0;
        n_out = 0;
        io.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_rand();
            #1;
            if (io.out_valid && exp_q.size() > 0) check("stall_hold", io.out_sample, exp_q[0]);
            cycle();
        end
        #1;
        check("bp_accepts_stalled", n_acc, 3);
        check("bp_in_ready_low", io.in_ready, 0);
        io.out_ready = 1'b1;
        for (int i = 0; i < 30 && n_acc < 8; i++) begin
            drive_rand();
            cycle();
        end
        drain();
        check("bp_accepts", n_acc, 8);
        check("bp_outputs", n_out, 8);

        n_acc = 0;
        n_out = 0;
        io.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            cycle();
        end
        check("full_fill", n_acc, 3);
        for (int i = 0; i < 10; i++) begin
            drive_rand();
            io.out_ready = 1'b1;
            #1;
            check("full_in_ready", io.in_ready, 1);
            check("full_out_valid", io.out_valid, 1);
            check("full_occupancy", exp_q.size(), 3);
            cycle();
        end
        drain();
        check("full_accepts", n_acc, 13);
        check("full_outputs", n_out, 13);

        io.out_ready = 1'b1;
        drive_rand();
        cycle();
        drive_rand();
        cycle();
        io.in_valid  = 1'b0;
        io.out_ready = 1'b0;
        cycle();
        check("pre_rst_out_valid", io.out_valid, 1);
        check("pre_rst_inflight", exp_q.size(), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", io.out_valid, 0);
        check("mid_rst_out_sample", io.out_sample, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", io.in_ready, 1);
        check("post_rst_out_valid", io.out_valid, 0);
        @(negedge clk);
        io.out_ready = 1'b1;
        drive(7, 0, rnd_y(), rnd_y(), rnd_y(), rnd_y());
        single("post_rst", exp_cur);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/interp_sum_stage.md
# interp_sum_stage

Downstream combining stage of the 4-tap fractional-sample interpolation filter. It consumes the 15 multiple-constant outputs of each tap MCM block (t1..t4, one per fractional position 1..15). For each accepted sample it selects the four products for the requested fraction, applies the tap signs, sums, rounds, shifts and clips. The result is a filtered sample on a valid/ready stream with a fixed 3-cycle pipeline.

## Interface
- BIT_DEPTH, 10, output sample bit depth; clip range is [0, 2^BIT_DEPTH-1]
- SHIFT, 6, normalisation right shift; rounding offset is 2^(SHIFT-1)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  upstream has a sample set
- in_ready  output  1  stage accepts the current set this cycle
- in_frac  input  4  fractional position 0..15
- in_sample  input  32  signed integer-position sample, used only when in_frac==0
- t1_bus, t2_bus, t3_bus, t4_bus  input  480 each  tap MCM outputs; slice [32k-1:32(k-1)] is Yk (frac k), signed
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_sample  output  16  signed result

## Operation
- Accept: a set is taken when in_valid && in_ready.
- S1, select:
  - Register p1..p4 = tN_bus slice in_frac.
  - For in_frac==0, register p2 = in_sample << SHIFT and p1 = p3 = p4 = 0.
- S2, partial sums with TAP_SIGN from the package:
  - Register a = p2 - p1.
  - Register b = p3 - p4.
- S3, final:
  - s = a + b + 2^(SHIFT-1).
  - r = s >>> SHIFT (arithmetic shift).
  - Clip or truncate r per Configuration, then register it as out_sample.
- Arithmetic: 32-bit signed throughout, no overflow handling inside the pipe; the upstream range guarantees |sum| < 2^30.
- Each stage has a valid bit v1..v3. Stage enable is en_k = !v_k || en_(k+1), with en_4 = out_ready.
- in_ready = en_1. This is combinational from out_ready and the valid bits; bubbles collapse.
- Data registers load only when their stage is enabled; held data stays stable while stalled.

## Timing
- Reset: v1..v3=0, out_valid=0, out_sample=0, all data registers 0, in_ready=1 once reset deasserts.
- Latency: 3 cycles from accept to out_valid, with no stall.
- Throughput: 1 set/cycle while out_ready=1.
- Stall: out_valid && !out_ready holds out_sample unchanged. Upstream stages keep filling until full, then in_ready=0.
- Simultaneous output accept and input accept in a full pipe: both occur, and occupancy stays 3.
- Reset mid-operation: all in-flight sets are discarded immediately, with no partial output.
- in_frac value change while in_valid && !in_ready: ignored until accept.

## Configuration
- INTERP_SUM_CLIP_EN defined:
  - out_sample = clip(r, 0, 2^BIT_DEPTH-1), zero-extended to 16 bits.
  - This is the final-pass mode.
- Not defined:
  - out_sample = r[15:0] as signed, with no clip.
  - This is the intermediate-pass mode for the second filter dimension.

## Structure
- Shared package interp_pkg:
  - NUM_TAPS=4 and NUM_FRAC=15.
  - TAP_SIGN constant: tap1 and tap4 negative, tap2 and tap3 positive.
  - typedef for the 32-bit signed product.
  - typedef for the stage valid/data bundle.
- Sub-module interp_tap_sel: a combinational slice mux from a 480-bit bus and in_frac to a 32-bit product, returning 0 for frac 0. It is instantiated once per tap.
- The MCM blocks t1..t4 stay outside and are wired to the buses at the filter top.

## Test plan
- Basic sum, clip on: frac=2, p1=200, p2=6200, p3=400, p4=0, out_ready=1 -> sum 6400 -> out_sample=100 exactly 3 cycles after accept.
- Integer position: frac=0, in_sample=517, tap buses randomised -> out_sample=517 (buses ignored).
- Clip bounds, clip on, BIT_DEPTH=10:
  - Sum -6400 -> 0.
  - Sum 80000 -> 1023.
  - Same sets with macro undefined -> -100 and 1250.
- Back-pressure:
  - Stream 8 sets and hold out_ready=0 for 5 cycles.
  - in_ready must drop after 3 accepts, and out_sample must hold its value.
  - After release, all 8 results must come out in order with no loss or duplication.
- Full-pipe concurrency: pipe full, out_ready=1 and in_valid=1 every cycle -> one output and one accept every cycle, occupancy stays 3.
- Async reset with 2 sets in flight: rst_n low mid-cycle -> out_valid=0 immediately and in_ready=1 after release. The first post-reset set yields its correct result after 3 cycles.
